paddle_ctrl: RTL

PADDLE_CTRL -- requirements
Module: paddle_ctrl

---
 rtl/pong_pkg.sv | 36 +++
 rtl/paddle_ctrl_if.sv | 20 ++
 rtl/btn_debounce.sv | 36 +++
 rtl/paddle_ctrl.sv | 102 ++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared screen constants, FSM encoding and clamped step helper
package pong_pkg;

    localparam int SCREEN_LINES = 768;
    localparam int COORD_W      = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SLOW = 2'd1,
        ST_FAST = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    // One frame of motion in 12-bit arithmetic, pinned to [0, limit] so it never wraps
    function automatic logic [11:0] step_pos(
        input logic [11:0] pos,
        input logic [11:0] step,
        input logic [11:0] limit,
        input dir_t        dir
    );
        logic [11:0] sum;
        sum      = pos + step;
        step_pos = pos;
        case (dir)
            DIR_UP:   step_pos = (pos < step) ? 12'd0 : pos - step;
            DIR_DOWN: step_pos = (sum > limit) ? limit : sum;
            default:  step_pos = pos;
        endcase
    endfunction

endpackage

// File: rtl/paddle_ctrl_if.sv
// rtl/paddle_ctrl_if.sv - button/vsync inputs and paddle outputs of paddle_ctrl
interface paddle_ctrl_if;
    import pong_pkg::*;

    logic               btn_up;
    logic               btn_down;
    logic               vsync_in;
    logic [COORD_W-1:0] pallete_position;
    logic               moving;

    modport master (
        output btn_up, btn_down, vsync_in,
        input  pallete_position, moving
    );

    modport slave (
        input  btn_up, btn_down, vsync_in,
        output pallete_position, moving
    );
endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer followed by a stable-count debouncer
module btn_debounce #(
    parameter int DEB_CYCLES = 65000
) (
    input  logic pclk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level
);
    localparam int              CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;

    // Bring the raw pin into the pclk domain before anything looks at it
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], btn_raw};
    end

    // Adopt the new level only after DEB_CYCLES differing samples in a row
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            btn_level <= 1'b0;
        end else if (sync_q[1] == btn_level) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q     <= '0;
            btn_level <= sync_q[1];
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - paddle position controller with per-frame slow/fast motion
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int PALETTE_H    = 128,
    parameter int Y_MAX        = 640,
    parameter int INIT_POS     = 320,
    parameter int DEB_CYCLES   = 65000,
    parameter int SLOW_STEP    = 2,
    parameter int FAST_STEP    = 6,
    parameter int ACCEL_FRAMES = 16
) (
    input  logic          pclk,
    input  logic          rst_n,
    paddle_ctrl_if.slave  bus
);
    // Never let a misconfigured Y_MAX push the paddle past the bottom of the screen
    localparam int                Y_LIMIT    = (Y_MAX < SCREEN_LINES - PALETTE_H) ? Y_MAX
                                                                                  : SCREEN_LINES - PALETTE_H;
    localparam logic [11:0]       LIMIT12    = 12'(Y_LIMIT);
    localparam logic [11:0]       SLOW12     = 12'(SLOW_STEP);
    localparam logic [11:0]       FAST12     = 12'(FAST_STEP);
    localparam int                FCNT_W     = $clog2(ACCEL_FRAMES + 1);
    localparam logic [FCNT_W-1:0] ACCEL_LAST = FCNT_W'(ACCEL_FRAMES - 1);
    localparam logic [FCNT_W-1:0] ACCEL_FULL = FCNT_W'(ACCEL_FRAMES);

    logic               up_lvl;
    logic               down_lvl;
    logic               vs_q;
    logic               vs_d;
    logic               frame_tick;
    dir_t               dir;
    dir_t               dir_q;
    state_t             state_q;
    logic [FCNT_W-1:0]  fcnt_q;
    logic [COORD_W-1:0] pos_q;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .btn_raw   (bus.btn_up),
        .btn_level (up_lvl)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .btn_raw   (bus.btn_down),
        .btn_level (down_lvl)
    );

    // Register vsync and keep the previous sample to find its rising edge
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q <= 1'b0;
            vs_d <= 1'b0;
        end else begin
            vs_q <= bus.vsync_in;
            vs_d <= vs_q;
        end
    end

    assign frame_tick = vs_q & ~vs_d;

    // Exactly one button held selects a direction; both or neither means stand still
    always_comb begin
        dir = DIR_NONE;
        if (up_lvl && !down_lvl)      dir = DIR_UP;
        else if (down_lvl && !up_lvl) dir = DIR_DOWN;
    end

    // Motion FSM: only advances on frame_tick, so the drawn paddle never tears
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_NONE;
            fcnt_q  <= '0;
            pos_q   <= COORD_W'(INIT_POS);
        end else if (frame_tick) begin
            if (dir == DIR_NONE) begin
                state_q <= ST_IDLE;
                dir_q   <= DIR_NONE;
                fcnt_q  <= '0;
            end else if (state_q == ST_IDLE || dir != dir_q) begin
                state_q <= ST_SLOW;
                dir_q   <= dir;
                fcnt_q  <= '0;
                pos_q   <= COORD_W'(step_pos({1'b0, pos_q}, SLOW12, LIMIT12, dir));
            end else if (state_q == ST_SLOW && fcnt_q != ACCEL_LAST) begin
                fcnt_q  <= fcnt_q + FCNT_W'(1);
                pos_q   <= COORD_W'(step_pos({1'b0, pos_q}, SLOW12, LIMIT12, dir));
            end else begin
                state_q <= ST_FAST;
                fcnt_q  <= ACCEL_FULL;
                pos_q   <= COORD_W'(step_pos({1'b0, pos_q}, FAST12, LIMIT12, dir));
            end
        end
    end

    assign bus.pallete_position = pos_q;
    assign bus.moving           = (state_q != ST_IDLE);
endmodule
